// File: rtl/leb128_fetch.sv
// leb128_fetch: serial LEB128 immediate decoder between the code ROM and CPU decode.
// Optional feature macro LEB128_SIGNED_EN: when defined, signed_mode selects SLEB128
// sign extension; when undefined, signed_mode is ignored and results are zero-extended.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start             request pulse, sampled only when idle
//   addr              byte address of the first encoded byte
//   signed_mode       1 = SLEB128, 0 = ULEB128
//   width64           1 = 64-bit immediate (10 bytes max), 0 = 32-bit (5 bytes max)
//   busy, done        in-flight flag and one-cycle result-valid pulse
//   value, length     decoded 64-bit immediate and bytes consumed
//   error             0 ok, 1 ROM bounds error, 2 overlong encoding
//   mem_addr          registered ROM address
//   mem_extra         bytes requested beyond the first
//   mem_data          ROM window, byte at mem_addr in the top lane
//   mem_error         ROM bounds violation, valid alongside mem_data
module leb128_fetch #(
    parameter int MEM_DEPTH = 3,
    parameter int MEM_EXTRA = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [MEM_DEPTH:0]           addr,
    input  logic                         signed_mode,
    input  logic                         width64,
    output logic                         busy,
    output logic                         done,
    output logic [63:0]                  value,
    output logic [3:0]                   length,
    output logic [1:0]                   error,
    output logic [MEM_DEPTH:0]           mem_addr,
    output logic [MEM_EXTRA-1:0]         mem_extra,
    input  logic [(2**MEM_EXTRA)*8-1:0]  mem_data,
    input  logic                         mem_error
);
    localparam int WB = (2**MEM_EXTRA)*8;
    typedef enum logic [2:0] {IDLE, REQ, LOAD, DECODE, DONE} state_t;
    state_t state, state_n;
    logic [WB-1:0] win;
    logic [63:0] acc, acc_n, acc_t, fin;
    logic [7:0] cur;
    logic w64, over, last;
    assign cur = win[WB-1 -: 8];
    // length doubles as the byte index k; shifts past bit 63 fall off the 64-bit operand
    assign acc_n = acc | ({57'd0, cur[6:0]} << (7 * length));
    assign over = cur[7] && (length + 4'd1 == (w64 ? 4'd10 : 4'd5));
    assign last = !cur[7] || over;
    assign acc_t = w64 ? acc_n : {32'd0, acc_n[31:0]};
`ifdef LEB128_SIGNED_EN
    logic sgn;
    logic [6:0] n7, sb;
    logic [63:0] mask;
    // sign bit sits at min(7n, W)-1; everything above it is filled with that bit
    assign n7 = 7'(7 * (length + 4'd1));
    assign sb = (n7 > (w64 ? 7'd64 : 7'd32)) ? (w64 ? 7'd64 : 7'd32) : n7;
    assign mask = (64'd1 << sb) - 64'd1;
    assign fin = (sgn && acc_t[sb - 7'd1]) ? (acc_t | ~mask) : acc_t;
`else
    logic unused_signed;
    assign unused_signed = signed_mode;
    assign fin = acc_t;
`endif
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        busy = state != IDLE;
        done = state == DONE;
        case (state)
            IDLE:    state_n = start ? REQ : IDLE;
            REQ:     state_n = LOAD;
            LOAD:    state_n = mem_error ? DONE : DECODE;
            DECODE:  state_n = last ? DONE : DECODE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
            length <= '0;
            error <= '0;
            mem_addr <= '0;
            mem_extra <= '0;
            acc <= '0;
            win <= '0;
            w64 <= 1'b0;
`ifdef LEB128_SIGNED_EN
            sgn <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    mem_addr <= addr;
                    mem_extra <= width64 ? MEM_EXTRA'(9) : MEM_EXTRA'(4);
                    w64 <= width64;
`ifdef LEB128_SIGNED_EN
                    sgn <= signed_mode;
`endif
                    acc <= '0;
                    length <= '0;
                    error <= '0;
                end
                LOAD: if (mem_error) begin
                    error <= 2'd1;
                    value <= '0;
                    length <= '0;
                end else begin
                    win <= mem_data;
                end
                DECODE: begin
                    acc <= acc_n;
                    length <= length + 4'd1;
                    win <= win << 8;
                    if (last) begin
                        value <= fin;
                        error <= over ? 2'd2 : 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_leb128_fetch.sv
// tb_leb128_fetch: directed and random checks of leb128_fetch against a ROM model and an arithmetic LEB128 reference.
module tb_leb128_fetch;
`ifdef LEB128_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, signed_mode = 1'b0, width64 = 1'b0;
    logic [3:0] addr = '0;
    logic busy, done, mem_error;
    logic [63:0] value;
    logic [3:0] length, mem_addr, mem_extra;
    logic [1:0] error;
    logic [127:0] mem_data;
    logic [7:0] rom [16];
    int ub = 15;
    int vectors = 0, miscompares = 0;

    leb128_fetch dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr),
        .signed_mode(signed_mode), .width64(width64), .busy(busy), .done(done),
        .value(value), .length(length), .error(error), .mem_addr(mem_addr),
        .mem_extra(mem_extra), .mem_data(mem_data), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    // ROM: window and bounds flag appear one cycle after the address
    always @(posedge clk) begin : rom_model
        logic [127:0] w;
        for (int i = 0; i < 16; i++) w[127 - 8*i -: 8] = rom[4'(int'(mem_addr) + i)];
        mem_data <= w;
        mem_error <= (int'(mem_addr) + int'(mem_extra)) > ub;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // LEB128 meaning computed arithmetically: sum of 7-bit groups, reduced mod 2**min(7n,W), optionally two's complement
    function automatic logic [63:0] ref_val(input logic [7:0] enc [10], input int n, input bit sm, input bit w);
        logic [127:0] a = '0;
        int sb = (7*n < (w ? 64 : 32)) ? 7*n : (w ? 64 : 32);
        for (int i = 0; i < n; i++) a = a + ({121'd0, enc[i][6:0]} << (7*i));
        a = a & ((128'd1 << sb) - 128'd1);
        if (sm && SIGNED_EN && a[sb-1]) a = a - (128'd1 << sb);
        return a[63:0];
    endfunction

    task automatic run(input string tag, input logic [3:0] a, input bit sm, input bit w,
                       input int cyc, input int n, input logic [1:0] e, input bit cv,
                       input logic [63:0] v, input bit poke);
        int c;
        @(negedge clk);
        addr = a; signed_mode = sm; width64 = w; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        chk({tag, ".mem_addr"}, 64'(mem_addr), 64'(a));
        chk({tag, ".mem_extra"}, 64'(mem_extra), w ? 64'd9 : 64'd4);
        if (poke) begin
            start = 1'b1; addr = ~a; signed_mode = ~sm; width64 = ~w;
        end
        while (done !== 1'b1 && c < 30) begin
            @(negedge clk);
            c++;
            start = 1'b0;
        end
        chk({tag, ".cycle"}, 64'(c), 64'(cyc));
        chk({tag, ".length"}, 64'(length), 64'(n));
        chk({tag, ".error"}, 64'(error), 64'(e));
        if (cv) chk({tag, ".value"}, value, v);
        @(negedge clk);
        chk({tag, ".done_pulse"}, 64'(done), 64'd0);
        chk({tag, ".idle"}, 64'(busy), 64'd0);
        if (cv) chk({tag, ".held"}, value, v);
    endtask

    initial begin
        logic [7:0] enc [10];
        bit any_done;
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
        repeat (2) @(negedge clk);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.value", value, 64'd0);
        chk("rst.length", 64'(length), 64'd0);
        chk("rst.error", 64'(error), 64'd0);
        chk("rst.mem_addr", 64'(mem_addr), 64'd0);
        chk("rst.mem_extra", 64'(mem_extra), 64'd0);
        reset = 1'b0;

        rom[0] = 8'h2A;
        run("u32_2a", 4'd0, 1'b0, 1'b0, 4, 1, 2'd0, 1'b1, 64'd42, 1'b0);
        rom[3] = 8'hE5; rom[4] = 8'h8E; rom[5] = 8'h26;
        run("u32_3b", 4'd3, 1'b0, 1'b0, 6, 3, 2'd0, 1'b1, 64'd624485, 1'b1);
        rom[1] = 8'h80; rom[2] = 8'h7F;
        run("s64_807f", 4'd1, 1'b1, 1'b1, 5, 2, 2'd0, 1'b1,
            SIGNED_EN ? 64'hFFFF_FFFF_FFFF_FF80 : 64'h3F80, 1'b0);
        for (int i = 0; i < 5; i++) rom[6 + i] = 8'h80;
        run("overlong32", 4'd6, 1'b0, 1'b0, 8, 5, 2'd2, 1'b1, 64'd0, 1'b0);
        ub = 2;
        run("rom_err", 4'd5, 1'b0, 1'b0, 3, 0, 2'd1, 1'b1, 64'd0, 1'b0);
        ub = 15;

        @(negedge clk);
        addr = 4'd3; signed_mode = 1'b0; width64 = 1'b0; start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid.busy", 64'(busy), 64'd0);
        chk("rstmid.done", 64'(done), 64'd0);
        chk("rstmid.value", value, 64'd0);
        chk("rstmid.length", 64'(length), 64'd0);
        chk("rstmid.error", 64'(error), 64'd0);
        chk("rstmid.mem_addr", 64'(mem_addr), 64'd0);
        chk("rstmid.mem_extra", 64'(mem_extra), 64'd0);
        any_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            any_done |= done;
        end
        chk("rstmid.no_done", 64'(any_done), 64'd0);
        run("after_rst", 4'd0, 1'b0, 1'b0, 4, 1, 2'd0, 1'b1, 64'd42, 1'b0);

        for (int t = 0; t < 40; t++) begin
            bit w, sm, ovl;
            int maxn, n;
            logic [3:0] a;
            w = 1'($urandom);
            sm = 1'($urandom);
            maxn = w ? 10 : 5;
            ovl = $urandom_range(0, 5) == 0;
            n = ovl ? maxn : $urandom_range(1, maxn);
            a = 4'($urandom_range(0, 15 - (w ? 9 : 4)));
            for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
            for (int i = 0; i < 10; i++) enc[i] = {(i < n - 1) || ovl, 7'($urandom)};
            for (int i = 0; i < n; i++) rom[int'(a) + i] = enc[i];
            run($sformatf("rnd%0d", t), a, sm, w, n + 3, n, ovl ? 2'd2 : 2'd0, !ovl,
                ref_val(enc, n, sm, w), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/leb128_fetch.md
# leb128_fetch

Immediate-operand fetch stage between the code ROM (`genrom`) and the `cpu` decode logic. On a one-cycle request it reads a window of bytecode at a given address and decodes one LEB128 immediate serially, one byte per cycle. It returns the decoded value sign- or zero-extended to 64 bits, plus the encoded length and an error code. The CPU uses it for `i32.const`, `i64.const`, branch depths and local/global indices.

## Interface
- `MEM_DEPTH`, default 3: ROM address MSB index; addresses are `MEM_DEPTH+1` bits wide.
- `MEM_EXTRA`, default 4: ROM window size is 2**MEM_EXTRA bytes; must be ≥4 so that 10 bytes fit.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request pulse; sampled only in IDLE.
- `addr`  in  MEM_DEPTH+1: byte address of the first LEB128 byte.
- `signed_mode`  in  1: 1 = SLEB128, 0 = ULEB128.
- `width64`  in  1: 1 = 64-bit immediate (maximum 10 bytes), 0 = 32-bit immediate (maximum 5 bytes).
- `busy`  out  1: high from the cycle after `start` until DONE exits.
- `done`  out  1: one-cycle pulse when the result is valid.
- `value`  out  64: decoded immediate; held until the next accepted `start`.
- `length`  out  4: number of bytes consumed (1–10).
- `error`  out  2: 0 = ok, 1 = ROM bounds error, 2 = overlong encoding.
- `mem_addr`  out  MEM_DEPTH+1: ROM address, driven by a register.
- `mem_extra`  out  MEM_EXTRA: additional bytes beyond the first; 9 if `width64`, else 4.
- `mem_data`  in  2**MEM_EXTRA*8: ROM window, valid one cycle after address. The byte at `mem_addr` is the most-significant lane.
- `mem_error`  in  1: ROM bounds violation, qualified in the same cycle as `mem_data`.

## Operation
- FSM states: IDLE, REQ, LOAD, DECODE, DONE.
- **IDLE**
  - If `start` is high, latch `addr`, `signed_mode` and `width64`.
  - Clear the accumulator, shift counter and `length`.
  - Go to REQ.
- **REQ**: `mem_addr`/`mem_extra` are presented to the ROM; go to LOAD.
- **LOAD**
  - If `mem_error`: `error`=1, `value`=0, `length`=0, go to DONE.
  - Otherwise capture the full window into a shift register and go to DECODE.
- **DECODE**, one byte per cycle, taking the top lane first:
  - OR `byte[6:0]` into the accumulator at bit offset 7·k, where k is the byte index; bits beyond bit 63 are discarded.
  - Increment `length`, then shift the window left by 8.
  - If `byte[7]`=0: finalise and go to DONE.
  - If `byte[7]`=1 and k+1 equals the maximum length (5 or 10): `error`=2, keep the partial accumulator, go to DONE.
- **Finalise**
  - 32-bit: truncate to bits [31:0].
  - Signed: sign-extend from bit min(7·n, W)−1, where n is the byte count and W is 32 or 64.
  - Unsigned: zero-extend.
  - Result is always presented on 64 bits.
- **DONE**: assert `done` for one cycle, go to IDLE.
- `start` while busy is ignored; there is no queueing.
- Reset at any state:
  - FSM returns to IDLE next edge.
  - `busy`=0, `done`=0, `value`=0, `length`=0, `error`=0.
  - `mem_addr`=0, `mem_extra`=0.
  - An in-flight decode is discarded.

## Timing
- `start` high in cycle 0 → REQ in cycle 1 (`mem_addr` valid) → LOAD in cycle 2 (`mem_data` valid).
- DECODE runs in cycles 3..n+2; DONE/`done` high in cycle n+3 for an n-byte encoding.
- ROM error path: `done` in cycle 3.
- `value`, `length` and `error` are stable from the `done` cycle until the next accepted `start`.
- A new `start` may be presented in the cycle after `done`.

## Configuration
- `LEB128_SIGNED_EN` defined: the signed extension path is compiled in and `signed_mode` is honoured.
- Not defined: `signed_mode` is ignored, all immediates are zero-extended, and the sign-extend logic is removed.

## Test plan
- Unsigned, 32-bit, byte 0x2A at addr 0, `start` in cycle 0 → `done` in cycle 4, `value`=42, `length`=1, `error`=0.
- Unsigned, 32-bit, bytes E5 8E 26 → `done` in cycle 6, `value`=624485, `length`=3.
- Signed, 64-bit, bytes 80 7F → `value`=0xFFFFFFFFFFFFFF80, `length`=2. Without `LEB128_SIGNED_EN` → `value`=0x3F80.
- 32-bit, bytes 80 80 80 80 80 → `error`=2, `length`=5, `done` in cycle 8.
- `rom_upper_bound` set below `addr` so the ROM raises `mem_error` → `done` in cycle 3, `error`=1, `value`=0.
- `reset` asserted in cycle 4 of a 3-byte decode → all outputs 0 from cycle 5, no `done`. A fresh `start` then decodes 0x2A correctly.
